// File: rtl/fusion_pkg.sv
// Shared types and helpers for the fusion-unit psum accumulator.
//   state_e   : accumulator FSM states (ACCUM, HOLD)
//   NIBBLE_W  : bit width of one nibble position step
//   PSUM_W    : width of a partial product from the fusion unit
//   sat_add() : two's-complement add at a runtime width with clamp-on-overflow
package fusion_pkg;

    localparam int NIBBLE_W = 4;
    localparam int PSUM_W   = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
    } sat_res_t;

    // Operands are w-bit values zero-padded into 64 bits (w < 64). The sum is
    // returned in the low w bits, clamped to +max / -min when the add overflows.
    function automatic sat_res_t sat_add(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input int unsigned w);
        sat_res_t    res;
        logic [63:0] mask;
        logic [63:0] s;
        logic [5:0]  msb;
        logic        sa;
        logic        sb;
        logic        ss;
        mask    = (64'd1 << w) - 64'd1;
        msb     = 6'(w - 1);
        s       = (a + b) & mask;
        sa      = a[msb];
        sb      = b[msb];
        ss      = s[msb];
        res.ovf = (sa == sb) && (ss != sa);
        if (res.ovf) res.sum = sa ? (64'd1 << msb) : (mask >> 1);
        else         res.sum = s;
        return res;
    endfunction

endpackage

// File: rtl/fusion_psum_extend.sv
// Combinational term builder: sign- or zero-extends an 8-bit partial product
// to ACC_W bits and shifts it left by 4*psum_shift.
//   psum_in     : partial product
//   psum_signed : 1 = two's-complement input
//   psum_shift  : nibble position
//   term        : extended, shifted term truncated to ACC_W
module fusion_psum_extend
    import fusion_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 2
) (
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic               psum_signed,
    input  logic [SHIFT_W-1:0] psum_shift,
    output logic [ACC_W-1:0]   term
);

    logic [ACC_W-1:0]   ext;
    logic [SHIFT_W+1:0] sh_amt;
    logic               fill;

    assign fill   = psum_signed & psum_in[PSUM_W-1];
    assign ext    = {{(ACC_W-PSUM_W){fill}}, psum_in};
    // 4*psum_shift as a plain concatenation keeps the shifter small
    assign sh_amt = {psum_shift, 2'b00};
    assign term   = ext << sh_amt;

endmodule

// File: rtl/fusion_psum_accum.sv
// Consumer end of the fusion-unit psum interface. Accumulates shifted,
// extended partial products until a "last" beat and presents the composed
// result on a valid/ready output.
//   clk, rst_n          : clock, async active-low reset
//   psum_*              : beat input (valid/ready) with sign, shift and last
//   acc_out/acc_valid/acc_ready : composed result handshake
//   beat_cnt            : beats accepted for the current result (saturating)
//   sat_flag            : saturation seen in the current result
// Build option: define FUSION_ACC_SAT_EN for clamping adds; otherwise adds
// wrap and sat_flag is constant 0.
//
// state | meaning
// ACCUM | accepting beats, summing into acc
// HOLD  | result presented, waiting for acc_ready
module fusion_psum_accum
    import fusion_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic               psum_signed,
    input  logic [SHIFT_W-1:0] psum_shift,
    input  logic               psum_last,
    input  logic               psum_valid,
    output logic               psum_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [7:0]         beat_cnt,
    output logic               sat_flag
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             acc_valid_q, acc_valid_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;
    logic             accept;

    fusion_psum_extend #(
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_extend (
        .psum_in     (psum_in),
        .psum_signed (psum_signed),
        .psum_shift  (psum_shift),
        .term        (term)
    );

`ifdef FUSION_ACC_SAT_EN
    sat_res_t               sat_res;
    logic [63-ACC_W:0]      sat_res_unused;
    assign sat_res        = sat_add(64'(acc_q), 64'(term), ACC_W);
    assign sum            = sat_res.sum[ACC_W-1:0];
    assign sum_ovf        = sat_res.ovf;
    assign sat_res_unused = sat_res.sum[63:ACC_W];
`else
    assign sum     = acc_q + term;
    assign sum_ovf = 1'b0;
`endif

    assign psum_ready = (state_q == ACCUM);
    assign accept     = psum_valid && psum_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        beat_cnt_d  = beat_cnt_q;
        sat_d       = sat_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
                    sat_d      = sat_q | sum_ovf;
                    if (psum_last) begin
                        acc_out_d   = sum;
                        acc_valid_d = 1'b1;
                        acc_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    acc_valid_d = 1'b0;
                    beat_cnt_d  = 8'd0;
                    sat_d       = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            beat_cnt_q  <= 8'd0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            beat_cnt_q  <= beat_cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign beat_cnt  = beat_cnt_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fusion_psum_accum.sv
module tb_fusion_psum_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  psum_in;
    logic        psum_signed;
    logic [1:0]  psum_shift;
    logic        psum_last;
    logic        psum_valid;
    logic        psum_ready;
    logic [23:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  beat_cnt;
    logic        sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FUSION_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bit [7:0] q_p[$];
    bit       q_s[$];
    bit [1:0] q_sh[$];

    fusion_psum_accum #(.ACC_W(24), .SHIFT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .psum_in     (psum_in),
        .psum_signed (psum_signed),
        .psum_shift  (psum_shift),
        .psum_last   (psum_last),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .acc_out     (acc_out),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .beat_cnt    (beat_cnt),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each term is the integer value of the byte times 16^shift;
    // the result is the running integer sum (clamped per add when saturating),
    // reduced to 24 bits.
    function automatic void model(output logic [23:0] res, output bit sat);
        longint sum = 0;
        longint t;
        sat = 1'b0;
        for (int i = 0; i < q_p.size(); i++) begin
            t = q_s[i] ? longint'($signed(q_p[i])) : longint'(q_p[i]);
            t = t * (longint'(1) << (4 * q_sh[i]));
            sum += t;
            if (SAT && sum > 64'sd8388607)  begin sum = 64'sd8388607;  sat = 1'b1; end
            if (SAT && sum < -64'sd8388608) begin sum = -64'sd8388608; sat = 1'b1; end
        end
        res = sum[23:0];
    endfunction

    task automatic push(input bit [7:0] p, input bit s, input bit [1:0] sh);
        q_p.push_back(p); q_s.push_back(s); q_sh.push_back(sh);
    endtask

    task automatic clear_q();
        q_p.delete(); q_s.delete(); q_sh.delete();
    endtask

    // Drives the queued beats; returns at the negedge after the last beat's edge.
    task automatic send_beats(input bit gaps);
        for (int i = 0; i < q_p.size(); i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                psum_valid = 1'b0;
                @(negedge clk);
            end
            psum_in     = q_p[i];
            psum_signed = q_s[i];
            psum_shift  = q_sh[i];
            psum_last   = (i == q_p.size() - 1);
            psum_valid  = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL reset_acc_valid got %0b want 0", acc_valid); else n_pass++;
        n_checks++; if (acc_out !== 24'h0) $display("FAIL reset_acc_out got %06h want 000000", acc_out); else n_pass++;
        n_checks++; if (beat_cnt !== 8'd0) $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat_flag got %0b want 0", sat_flag); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (psum_ready !== 1'b1) $display("FAIL reset_psum_ready got %0b want 1", psum_ready); else n_pass++;
    endtask

    task automatic test_unsigned_compose();
        clear_q();
        push(8'h0F, 0, 0); push(8'h0A, 0, 1); push(8'h0C, 0, 1); push(8'h08, 0, 2);
        send_beats(1'b0);
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL u8x8_latency acc_valid got %0b want 1", acc_valid); else n_pass++;
        n_checks++; if (acc_out !== 24'h00096F) $display("FAIL u8x8_acc_out got %06h want 00096f", acc_out); else n_pass++;
        n_checks++; if (beat_cnt !== 8'd4) $display("FAIL u8x8_beat_cnt got %0d want 4", beat_cnt); else n_pass++;
        handshake();
        n_checks++; if (acc_valid !== 1'b0 || psum_ready !== 1'b1) $display("FAIL u8x8_release valid=%0b ready=%0b want 0/1", acc_valid, psum_ready); else n_pass++;
    endtask

    task automatic test_signed_single();
        clear_q(); push(8'hF8, 1, 0);
        send_beats(1'b0);
        n_checks++; if (acc_out !== 24'hFFFFF8) $display("FAIL signed_single got %06h want fffff8", acc_out); else n_pass++;
        n_checks++; if (beat_cnt !== 8'd1) $display("FAIL signed_single_cnt got %0d want 1", beat_cnt); else n_pass++;
        handshake();
        clear_q(); push(8'hF8, 0, 0);
        send_beats(1'b0);
        n_checks++; if (acc_out !== 24'h0000F8) $display("FAIL unsigned_single got %06h want 0000f8", acc_out); else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        clear_q(); push(8'h55, 0, 0);
        send_beats(1'b0);
        psum_in = 8'h12; psum_signed = 1'b0; psum_shift = 2'd0; psum_last = 1'b1; psum_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (acc_valid !== 1'b1 || acc_out !== 24'h000055) $display("FAIL bp_hold cyc %0d valid=%0b out=%06h want 1/000055", i, acc_valid, acc_out); else n_pass++;
            n_checks++; if (psum_ready !== 1'b0) $display("FAIL bp_ready cyc %0d got %0b want 0", i, psum_ready); else n_pass++;
            @(negedge clk);
        end
        acc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_ready = 1'b0;
        n_checks++; if (acc_valid !== 1'b0 || beat_cnt !== 8'd0 || psum_ready !== 1'b1) $display("FAIL bp_release valid=%0b cnt=%0d ready=%0b want 0/0/1", acc_valid, beat_cnt, psum_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0; psum_last = 1'b0;
        n_checks++; if (acc_valid !== 1'b1 || acc_out !== 24'h000012 || beat_cnt !== 8'd1) $display("FAIL bp_held_beat valid=%0b out=%06h cnt=%0d want 1/000012/1", acc_valid, acc_out, beat_cnt); else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        psum_in = 8'h44; psum_signed = 1'b0; psum_shift = 2'd2; psum_last = 1'b0; psum_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        n_checks++; if (beat_cnt !== 8'd2) $display("FAIL mid_pre_cnt got %0d want 2", beat_cnt); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (acc_valid !== 1'b0 || beat_cnt !== 8'd0) $display("FAIL mid_reset valid=%0b cnt=%0d want 0/0", acc_valid, beat_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        clear_q(); push(8'h31, 0, 1);
        send_beats(1'b0);
        n_checks++; if (acc_out !== 24'h000310) $display("FAIL mid_after got %06h want 000310", acc_out); else n_pass++;
        handshake();
    endtask

    task automatic test_overflow();
        clear_q();
        for (int i = 0; i < 16; i++) push(8'h7F, 1, 3);
        send_beats(1'b0);
        n_checks++; if (acc_out !== 24'h7F0000 || sat_flag !== 1'b0) $display("FAIL ovf16 out=%06h sat=%0b want 7f0000/0", acc_out, sat_flag); else n_pass++;
        handshake();
        clear_q();
        for (int i = 0; i < 17; i++) push(8'h7F, 1, 3);
        send_beats(1'b0);
        if (SAT) begin
            n_checks++; if (acc_out !== 24'h7FFFFF || sat_flag !== 1'b1) $display("FAIL ovf17 out=%06h sat=%0b want 7fffff/1", acc_out, sat_flag); else n_pass++;
        end else begin
            n_checks++; if (acc_out !== 24'h86F000 || sat_flag !== 1'b0) $display("FAIL ovf17 out=%06h sat=%0b want 86f000/0", acc_out, sat_flag); else n_pass++;
        end
        n_checks++; if (beat_cnt !== 8'd17) $display("FAIL ovf17_cnt got %0d want 17", beat_cnt); else n_pass++;
        handshake();
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL ovf_sat_clear got %0b want 0", sat_flag); else n_pass++;
    endtask

    task automatic test_random();
        logic [23:0] exp_res;
        bit          exp_sat;
        for (int r = 0; r < 12; r++) begin
            int n;
            clear_q();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++)
                push(8'($urandom), 1'($urandom), 2'($urandom));
            model(exp_res, exp_sat);
            send_beats(1'b1);
            n_checks++; if (acc_valid !== 1'b1 || acc_out !== exp_res) $display("FAIL rand_%0d out=%06h valid=%0b want %06h/1", r, acc_out, acc_valid, exp_res); else n_pass++;
            n_checks++; if (beat_cnt !== 8'(n) || sat_flag !== exp_sat) $display("FAIL rand_%0d_meta cnt=%0d sat=%0b want %0d/%0b", r, beat_cnt, sat_flag, n, exp_sat); else n_pass++;
            handshake();
        end
    endtask

    initial begin
        psum_in = 8'h0; psum_signed = 1'b0; psum_shift = 2'd0;
        psum_last = 1'b0; psum_valid = 1'b0; acc_ready = 1'b0;
        test_reset();
        test_unsigned_compose();
        test_signed_single();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fusion_psum_accum.md
Name: fusion_psum_accum

Overview:
- Consumer end of the fusion-unit psum interface.
- Takes 8-bit partial products (psum_fwd) from a 4x4 fusion unit, sign- or zero-extends each one, and shift-composes it by its nibble position.
- Accumulates beats until a "last" beat, then presents the composed result on a valid/ready output.
- Sits between a fusion-unit array column and the output buffer; supports wider (8b/16b) products built from 4-bit sub-products.

Parameters:
- ACC_W, 24, accumulator and output width (min 16).
- SHIFT_W, 2, width of the nibble-position field; effective shift = 4*psum_shift.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- psum_in  input  8  partial product from the fusion unit.
- psum_signed  input  1  1 = psum_in is two's-complement (either operand signed); 0 = unsigned.
- psum_shift  input  SHIFT_W  nibble position; term is shifted left by 4*psum_shift.
- psum_last  input  1  marks the final beat of the current result.
- psum_valid  input  1  beat present.
- psum_ready  output  1  block accepts a beat.
- acc_out  output  ACC_W  composed result.
- acc_valid  output  1  result present.
- acc_ready  input  1  downstream accepts the result.
- beat_cnt  output  8  beats accepted for the current result (saturates at 255).
- sat_flag  output  1  saturation occurred in the current result (only when the macro is defined; tied 0 otherwise).

Behaviour:
- Reset (async on rst_n low): state=ACCUM, acc=0, acc_out=0, acc_valid=0, beat_cnt=0, sat_flag=0. psum_ready=1 after reset deassertion.
- Reset mid-result discards all partial state; no output is produced for the aborted result.
- Term: ext = psum_signed ? sign-extend(psum_in) : zero-extend(psum_in), to ACC_W bits. term = ext << (4*psum_shift), truncated to ACC_W.
- Accept condition: psum_valid && psum_ready.
- State ACCUM:
  - psum_ready=1.
  - On accept with !psum_last: acc <= acc + term; beat_cnt increments.
  - On accept with psum_last: acc_out <= acc + term; acc_valid <= 1; acc <= 0; beat_cnt increments; go to HOLD.
- State HOLD:
  - psum_ready=0; acc_valid=1; acc_out held stable.
  - On acc_ready: acc_valid <= 0; beat_cnt <= 0; sat_flag <= 0; go to ACCUM.
- Latency: result appears one cycle after the last beat is accepted.
- Throughput: 1 beat per cycle. Minimum one bubble cycle between results (the HOLD handshake cycle).
- A single beat with psum_last=1 is a valid one-term result.
- psum_valid while psum_ready=0 must be held by the producer (standard valid/ready); the block ignores it.
- Arithmetic wraps modulo 2^ACC_W unless the optional feature is compiled in.
- Signed vs unsigned is decided per beat, so mixed-sign compositions (e.g. unsigned low nibble x signed high nibble) compose correctly.

Optional Feature:
- Macro: FUSION_ACC_SAT_EN.
- Defined:
  - Each add is checked for two's-complement overflow at ACC_W.
  - On overflow, the sum clamps to +max (0111..1) or -min (1000..0); sat_flag sets and stays set until the result handshake completes.
  - Clamping applies to the final add as well.
- Undefined: plain wrapping add; sat_flag is constant 0.

Decomposition:
- Package fusion_pkg:
  - state enum {ACCUM, HOLD}.
  - NIBBLE_W=4 and PSUM_W=8 constants.
  - Function sat_add(a, b) returning {sum, ovf}.
- One natural sub-module: fusion_psum_extend, a combinational sign/zero-extend plus nibble shift producing term.
- The accumulator and FSM stay in the top level.

Test Plan:
- Unsigned 8x8 composition: 0x23*0x45 as four beats, all unsigned:
  - (0x0F, shift0), (0x0A, shift1), (0x0C, shift1), (0x08, shift2, last).
  - Required: acc_out=2415 (0x00096F) one cycle after the last beat; beat_cnt=4.
- Signed single beat: psum_in=0xF8, psum_signed=1, shift0, last.
  - Required: acc_out=0xFFFFF8.
  - Same beat with psum_signed=0: acc_out=0x0000F8.
- Backpressure: result ready, acc_ready held 0 for 5 cycles.
  - Required: acc_valid=1 and acc_out stable throughout; psum_ready=0; a producer beat held valid is accepted only after the handshake.
- Reset mid-result: two beats accepted, then rst_n pulsed low.
  - Required: acc_valid=0 and beat_cnt=0 immediately; the next single-beat result equals that beat alone.
- Overflow: 17 beats of psum_in=0x7F, signed, shift3 (127<<12 each), last on the 17th.
  - With FUSION_ACC_SAT_EN: acc_out=0x7FFFFF, sat_flag=1.
  - Without the macro: acc_out=0x86F000, sat_flag=0.
  - 16 beats only: acc_out=0x7F0000 in both builds.
